// File: rtl/game_pkg.sv
// Shared screen encodings and constants for the game video path.
// screen_t is also used by the game FSM.
package game_pkg;

  typedef enum logic [1:0] {
    SCR_PLAY = 2'd0,
    SCR_WIN  = 2'd1,
    SCR_LOSE = 2'd2
  } screen_t;

  localparam logic [23:0] BLACK_PIXEL = 24'h000000;

endpackage

// File: rtl/game_screen_sel_frame_hold_counter.sv
// Counts frame ticks while a timed screen is shown and flags the tick that ends the hold.
// Reusable for any screen that must stay up for a fixed number of whole frames.
module frame_hold_counter #(
  parameter int HOLD_FRAMES = 180,
  parameter int CNT_W       = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_FRAMES - 1);

  logic [CNT_W-1:0] frame_cnt;

  // expire is combinational so the owner can act on the same boundary
  assign expire = tick && (frame_cnt == LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      frame_cnt <= '0;
    end else if (clear || expire) begin
      frame_cnt <= '0;
    end else if (tick) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_screen_sel.sv
// Picks the pixel stream for HDMI (gameplay, win or lose screen), switching only at
// frame boundaries, and registers pixel and sync together with one cycle of latency.
module game_screen_sel
  import game_pkg::*;
#(
  parameter int HOLD_FRAMES = 180,
  parameter int FRAME_CNT_W = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic        new_frame_in,
  input  logic        win_in,
  input  logic        lose_in,
  input  logic [23:0] play_pixel_in,
  input  logic [23:0] win_pixel_in,
  input  logic [23:0] lose_pixel_in,
  output logic [23:0] pixel_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic [1:0]  screen_out,
  output logic        done_out
);

  // pend uses SCR_PLAY to mean "no pending event"
  screen_t state, state_next;
  screen_t pend, pend_next;
  screen_t req;
  logic    hold_clear, hold_tick, hold_expire;

  frame_hold_counter #(
    .HOLD_FRAMES(HOLD_FRAMES),
    .CNT_W      (FRAME_CNT_W)
  ) u_hold (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .clear (hold_clear),
    .tick  (hold_tick),
    .expire(hold_expire)
  );

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= SCR_PLAY;
      pend     <= SCR_PLAY;
      done_out <= 1'b0;
    end else begin
      state    <= state_next;
      pend     <= pend_next;
      done_out <= hold_expire;
    end
  end

  always_comb begin
    state_next = state;
    pend_next  = pend;
    hold_clear = 1'b0;
    hold_tick  = 1'b0;
    req        = SCR_PLAY;
    case (state)
      SCR_PLAY: begin
        // an event in the boundary cycle takes effect at that same boundary
        if (win_in)       req = SCR_WIN;
        else if (lose_in) req = SCR_LOSE;
        else              req = pend;
        if (new_frame_in && req != SCR_PLAY) begin
          state_next = req;
          pend_next  = SCR_PLAY;
          hold_clear = 1'b1;
        end else if (pend == SCR_PLAY && (win_in || lose_in)) begin
          pend_next = win_in ? SCR_WIN : SCR_LOSE;
        end
      end
      SCR_WIN, SCR_LOSE: begin
        hold_tick = new_frame_in;
        if (hold_expire) state_next = SCR_PLAY;
      end
      default: state_next = SCR_PLAY;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pixel_out <= BLACK_PIXEL;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b1;
    end else begin
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
      blank_out <= blank_in;
      if (blank_in) begin
        pixel_out <= BLACK_PIXEL;
      end else begin
        case (state)
          SCR_WIN:  pixel_out <= win_pixel_in;
          SCR_LOSE: pixel_out <= lose_pixel_in;
          default:  pixel_out <= play_pixel_in;
        endcase
      end
    end
  end

  assign screen_out = state;

endmodule

// File: tb/tb_game_screen_sel.sv
// Directed bench for game_screen_sel with HOLD_FRAMES = 3.
module tb_game_screen_sel;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        hsync_in, vsync_in, blank_in, new_frame_in, win_in, lose_in;
  logic [23:0] play_pixel_in, win_pixel_in, lose_pixel_in;
  logic [23:0] pixel_out;
  logic        hsync_out, vsync_out, blank_out, done_out;
  logic [1:0]  screen_out;

  int tests_run = 0;
  int tests_failed = 0;

  game_screen_sel #(.HOLD_FRAMES(3), .FRAME_CNT_W(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blank_in(blank_in),
    .new_frame_in(new_frame_in), .win_in(win_in), .lose_in(lose_in),
    .play_pixel_in(play_pixel_in), .win_pixel_in(win_pixel_in), .lose_pixel_in(lose_pixel_in),
    .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .blank_out(blank_out), .screen_out(screen_out), .done_out(done_out)
  );

  always #5 clk_in = ~clk_in;

  // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame_pulse();
    new_frame_in = 1'b1;
    step();
    new_frame_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b0;
    new_frame_in = 1'b0; win_in = 1'b0; lose_in = 1'b0;
    play_pixel_in = 24'h123456; win_pixel_in = 24'h008000; lose_pixel_in = 24'h800000;
    idle(3);
    tests_run++;
    if (pixel_out !== 24'h0 || hsync_out !== 1'b0 || vsync_out !== 1'b0 || blank_out !== 1'b1 ||
        screen_out !== 2'd0 || done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: pix=%h hs=%b vs=%b bl=%b scr=%0d done=%b required 000000 0 0 1 0 0",
               pixel_out, hsync_out, vsync_out, blank_out, screen_out, done_out);
    end
    $display("[TB] reset: pix=%h bl=%b scr=%0d", pixel_out, blank_out, screen_out);
    rst_in = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic test_play();
    blank_in = 1'b0;
    step();
    tests_run++;
    if (pixel_out !== 24'h123456 || screen_out !== 2'd0 || blank_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL play_pixel: pix=%h scr=%0d bl=%b required 123456 0 0", pixel_out, screen_out, blank_out);
    end
    blank_in = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    step();
    tests_run++;
    if (pixel_out !== 24'h0 || blank_out !== 1'b1 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL play_sync: pix=%h bl=%b hs=%b vs=%b required 000000 1 1 1",
               pixel_out, blank_out, hsync_out, vsync_out);
    end
    hsync_in = 1'b0; vsync_in = 1'b0;
    step();
    tests_run++;
    if (hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL play_sync_fall: hs=%b vs=%b required 0 0", hsync_out, vsync_out);
    end
    $display("[TB] play: pix=%h scr=%0d", pixel_out, screen_out);
  endtask

  task automatic test_win_boundary();
    blank_in = 1'b0;
    win_in = 1'b1;
    step();
    win_in = 1'b0;
    idle(499);
    tests_run++;
    if (screen_out !== 2'd0) begin
      tests_failed++;
      $display("FAIL win_pending: scr=%0d required 0", screen_out);
    end
    new_frame_in = 1'b1;
    step();
    new_frame_in = 1'b0;
    tests_run++;
    // the boundary cycle itself still shows the gameplay pixel
    if (screen_out !== 2'd1 || pixel_out !== 24'h123456) begin
      tests_failed++;
      $display("FAIL win_switch: scr=%0d pix=%h required 1 123456", screen_out, pixel_out);
    end
    step();
    tests_run++;
    if (pixel_out !== 24'h008000) begin
      tests_failed++;
      $display("FAIL win_pixel: pix=%h required 008000", pixel_out);
    end
    $display("[TB] win boundary: scr=%0d pix=%h", screen_out, pixel_out);
  endtask

  task automatic test_hold();
    int dones;
    dones = 0;
    frame_pulse();
    tests_run++;
    if (screen_out !== 2'd1 || done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_1: scr=%0d done=%b required 1 0", screen_out, done_out);
    end
    idle(5);
    frame_pulse();
    tests_run++;
    if (screen_out !== 2'd1 || done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL hold_2: scr=%0d done=%b required 1 0", screen_out, done_out);
    end
    idle(5);
    frame_pulse();
    tests_run++;
    if (screen_out !== 2'd0 || done_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL hold_3: scr=%0d done=%b required 0 1", screen_out, done_out);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (done_out) dones++;
    end
    tests_run++;
    if (dones != 0 || screen_out !== 2'd0) begin
      tests_failed++;
      $display("FAIL hold_done_width: extra_done=%0d scr=%0d required 0 0", dones, screen_out);
    end
    $display("[TB] hold: scr=%0d extra_done=%0d", screen_out, dones);
  endtask

  task automatic test_priority_blank();
    win_in = 1'b1; lose_in = 1'b1; new_frame_in = 1'b1;
    step();
    win_in = 1'b0; lose_in = 1'b0; new_frame_in = 1'b0;
    tests_run++;
    if (screen_out !== 2'd1) begin
      tests_failed++;
      $display("FAIL priority: scr=%0d required 1", screen_out);
    end
    blank_in = 1'b1; win_pixel_in = 24'hFFFFFF;
    step();
    tests_run++;
    if (pixel_out !== 24'h0) begin
      tests_failed++;
      $display("FAIL blank_win: pix=%h required 000000", pixel_out);
    end
    blank_in = 1'b0;
    step();
    tests_run++;
    if (pixel_out !== 24'hFFFFFF) begin
      tests_failed++;
      $display("FAIL unblank_win: pix=%h required ffffff", pixel_out);
    end
    lose_in = 1'b1;
    step();
    lose_in = 1'b0;
    for (int f = 0; f < 3; f++) begin
      idle(3);
      frame_pulse();
    end
    tests_run++;
    if (screen_out !== 2'd0) begin
      tests_failed++;
      $display("FAIL lose_ignored_exit: scr=%0d required 0", screen_out);
    end
    idle(3);
    frame_pulse();
    tests_run++;
    if (screen_out !== 2'd0) begin
      tests_failed++;
      $display("FAIL lose_not_queued: scr=%0d required 0", screen_out);
    end
    $display("[TB] priority/blank: scr=%0d", screen_out);
  endtask

  task automatic test_reset_mid_hold();
    int dones;
    dones = 0;
    // a pending LOSE blocks a later WIN
    lose_in = 1'b1;
    step();
    lose_in = 1'b0;
    idle(2);
    win_in = 1'b1;
    step();
    win_in = 1'b0;
    frame_pulse();
    tests_run++;
    if (screen_out !== 2'd2) begin
      tests_failed++;
      $display("FAIL lose_pending: scr=%0d required 2", screen_out);
    end
    step();
    tests_run++;
    if (pixel_out !== 24'h800000) begin
      tests_failed++;
      $display("FAIL lose_pixel: pix=%h required 800000", pixel_out);
    end
    frame_pulse();
    idle(2);
    frame_pulse();
    idle(2);
    rst_in = 1'b0;
    step();
    tests_run++;
    if (screen_out !== 2'd0 || pixel_out !== 24'h0 || blank_out !== 1'b1 || done_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold: scr=%0d pix=%h bl=%b done=%b required 0 000000 1 0",
               screen_out, pixel_out, blank_out, done_out);
    end
    rst_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) new_frame_in = 1'b1;
      step();
      new_frame_in = 1'b0;
      if (done_out) dones++;
    end
    tests_run++;
    if (dones != 0 || screen_out !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_no_done: done_pulses=%0d scr=%0d required 0 0", dones, screen_out);
    end
    $display("[TB] reset mid-hold: scr=%0d done_pulses=%0d", screen_out, dones);
  endtask

  initial begin
    test_reset();
    test_play();
    test_win_boundary();
    test_hold();
    test_priority_blank();
    test_reset_mid_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
